// File: rtl/azimuth_frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// azimuth_frame_loader_pkg : shared types and sizing helpers for the loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package azimuth_frame_loader_pkg;

  localparam int DEFAULT_SIZE        = 3200;
  localparam int DEFAULT_TDATA_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Bits needed to index 0..depth-1.
  function automatic int clogb2(input int depth);
    int r;
    r = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/azimuth_frame_loader_if.sv
// ---------------------------------------------------------------------------
// azimuth_frame_loader_if : AXI4-Stream frame channel from the DMA
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface azimuth_frame_loader_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

`default_nettype wire

// File: rtl/azimuth_frame_loader.sv
// ---------------------------------------------------------------------------
// azimuth_frame_loader : double-buffered sweep bitmap loader, swaps on trigger
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module azimuth_frame_loader
  import azimuth_frame_loader_pkg::*;
#(
  parameter int SIZE                 = DEFAULT_SIZE,
  parameter int C_S_AXIS_TDATA_WIDTH = DEFAULT_TDATA_WIDTH
) (
  input  wire logic              SYS_CLK,
  input  wire logic              SYS_RESETN,
  input  wire logic              EN,
  input  wire logic              TRIG,
  azimuth_frame_loader_if.slave  S_AXIS,
  output logic [SIZE-1:0]        DATA,
  output logic                   TRIG_OUT,
  output logic                   FRAME_READY,
  output logic                   FRAME_ERR,
  output logic [15:0]            UNDERRUN_CNT
);

  localparam int                 WORDS    = SIZE / C_S_AXIS_TDATA_WIDTH;
  localparam int                 IDX_W    = clogb2(WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  fill_idx;
  logic [SIZE-1:0]   shadow;
  logic              trig_q;
  logic              tready_q;

  logic              trig_rise;
  logic              accept;
  logic              at_last;
  logic              frame_done;
  logic              frame_bad;

  assign S_AXIS.tready = tready_q;
  assign FRAME_READY   = (state == ST_FULL);

  always_comb begin
    trig_rise  = TRIG & ~trig_q;
    accept     = EN & tready_q & S_AXIS.tvalid;
    at_last    = (fill_idx == LAST_IDX);
    frame_done = accept & at_last & S_AXIS.tlast;
    frame_bad  = accept & (at_last ^ S_AXIS.tlast);

    // Swap (FULL only) and frame completion (FILL only) are mutually exclusive.
    state_nxt = state;
    if (!EN) begin
      state_nxt = ST_FILL;
    end else begin
      if (trig_rise && (state == ST_FULL)) begin
        state_nxt = ST_FILL;
      end
      if (frame_done) begin
        state_nxt = ST_FULL;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      state        <= ST_FILL;
      fill_idx     <= '0;
      shadow       <= '0;
      DATA         <= '0;
      trig_q       <= 1'b0;
      tready_q     <= 1'b0;
      TRIG_OUT     <= 1'b0;
      FRAME_ERR    <= 1'b0;
      UNDERRUN_CNT <= '0;
    end else begin
      trig_q   <= TRIG;
      state    <= state_nxt;
      tready_q <= EN && (state_nxt == ST_FILL);

      if (!EN) begin
        DATA         <= '0;
        fill_idx     <= '0;
        TRIG_OUT     <= 1'b0;
        FRAME_ERR    <= 1'b0;
        UNDERRUN_CNT <= '0;
      end else begin
        TRIG_OUT <= trig_rise;

        if (trig_rise) begin
          if (state == ST_FULL) begin
            DATA <= shadow;
          end else begin
            // No complete frame: blank the sweep rather than replay stale data.
            DATA <= '0;
            if (UNDERRUN_CNT != 16'hFFFF) begin
              UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
            end
          end
        end

        if (accept) begin
          shadow[int'(fill_idx)*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] <= S_AXIS.tdata;
          if (frame_bad) begin
            FRAME_ERR <= 1'b1;
            fill_idx  <= '0;
          end else if (at_last) begin
            fill_idx  <= '0;
          end else begin
            fill_idx  <= fill_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_azimuth_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_azimuth_frame_loader : directed self-checking bench for the frame loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_azimuth_frame_loader;

  localparam int SIZE  = 3200;
  localparam int W     = 32;
  localparam int WORDS = SIZE / W;

  logic              SYS_CLK = 1'b0;
  logic              SYS_RESETN;
  logic              EN;
  logic              TRIG;
  logic [SIZE-1:0]   DATA;
  logic              TRIG_OUT;
  logic              FRAME_READY;
  logic              FRAME_ERR;
  logic [15:0]       UNDERRUN_CNT;

  int compared   = 0;
  int mismatched = 0;

  azimuth_frame_loader_if #(.W(W)) s_axis ();

  azimuth_frame_loader #(
    .SIZE                 (SIZE),
    .C_S_AXIS_TDATA_WIDTH (W)
  ) dut (
    .SYS_CLK      (SYS_CLK),
    .SYS_RESETN   (SYS_RESETN),
    .EN           (EN),
    .TRIG         (TRIG),
    .S_AXIS       (s_axis),
    .DATA         (DATA),
    .TRIG_OUT     (TRIG_OUT),
    .FRAME_READY  (FRAME_READY),
    .FRAME_ERR    (FRAME_ERR),
    .UNDERRUN_CNT (UNDERRUN_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_zero();
    return (DATA === '0) ? 32'd1 : 32'd0;
  endfunction

  // Number of DATA words differing from seed ^ k.
  function automatic logic [31:0] frame_errs(input logic [31:0] seed);
    int e;
    e = 0;
    for (int k = 0; k < WORDS; k++) begin
      if (DATA[k*W +: W] !== (seed ^ 32'(k))) e++;
    end
    return 32'(e);
  endfunction

  task automatic cycle();
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
  endtask

  // Called at a negedge; pushes words first..first+n-1, each valued seed ^ k.
  task automatic send(input int first, input int n, input logic [31:0] seed, input int last_idx);
    for (int k = first; k < first + n; k++) begin
      int   waits;
      logic acc;
      s_axis.tdata  = seed ^ 32'(k);
      s_axis.tlast  = (k == last_idx);
      s_axis.tvalid = 1'b1;
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits < 64) begin
        acc = s_axis.tready;
        cycle();
        waits++;
      end
      if (!acc) begin
        chk("send_timeout", 32'd0, 32'd1);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        return;
      end
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic trig_hi();
    TRIG = 1'b1;
    cycle();
  endtask

  task automatic trig_lo();
    TRIG = 1'b0;
    cycle();
    chk("trig_out_one_cycle", 32'(TRIG_OUT), 32'd0);
  endtask

  initial begin
    SYS_RESETN    = 1'b0;
    EN            = 1'b0;
    TRIG          = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(negedge SYS_CLK);

    chk("rst_data",      data_zero(),          32'd1);
    chk("rst_trig_out",  32'(TRIG_OUT),        32'd0);
    chk("rst_tready",    32'(s_axis.tready),   32'd0);
    chk("rst_ready",     32'(FRAME_READY),     32'd0);
    chk("rst_err",       32'(FRAME_ERR),       32'd0);
    chk("rst_underrun",  32'(UNDERRUN_CNT),    32'd0);

    SYS_RESETN = 1'b1;
    EN         = 1'b1;
    cycle();
    chk("tready_after_en", 32'(s_axis.tready), 32'd1);

    // Normal swap
    send(0, WORDS, 32'h0, WORDS - 1);
    chk("norm_ready_pre",  32'(FRAME_READY),   32'd1);
    chk("norm_tready_full", 32'(s_axis.tready), 32'd0);
    trig_hi();
    chk("norm_word1",      DATA[63:32],        32'd1);
    chk("norm_word99",     DATA[3199:3168],    32'd99);
    chk("norm_frame",      frame_errs(32'h0),  32'd0);
    chk("norm_trig_out",   32'(TRIG_OUT),      32'd1);
    chk("norm_ready_post", 32'(FRAME_READY),   32'd0);
    chk("norm_tready_post", 32'(s_axis.tready), 32'd1);
    trig_lo();

    // Underrun
    send(0, 40, 32'h1000_0000, WORDS - 1);
    trig_hi();
    chk("ur_data_blank",   data_zero(),        32'd1);
    chk("ur_cnt",          32'(UNDERRUN_CNT),  32'd1);
    chk("ur_trig_out",     32'(TRIG_OUT),      32'd1);
    chk("ur_ready",        32'(FRAME_READY),   32'd0);
    trig_lo();
    send(40, 60, 32'h1000_0000, WORDS - 1);
    chk("ur_ready_full",   32'(FRAME_READY),   32'd1);
    trig_hi();
    chk("ur_frame",        frame_errs(32'h1000_0000), 32'd0);
    chk("ur_cnt_hold",     32'(UNDERRUN_CNT),  32'd1);
    trig_lo();

    // Framing error: early TLAST, then a clean frame
    send(0, 50, 32'h2000_0000, 49);
    chk("fe_err",          32'(FRAME_ERR),     32'd1);
    chk("fe_not_ready",    32'(FRAME_READY),   32'd0);
    send(0, WORDS, 32'h3000_0000, WORDS - 1);
    chk("fe_ready",        32'(FRAME_READY),   32'd1);
    trig_hi();
    chk("fe_frame",        frame_errs(32'h3000_0000), 32'd0);
    chk("fe_err_sticky",   32'(FRAME_ERR),     32'd1);
    trig_lo();

    // EN low clears state; trigger held high across EN rise must not fire
    EN   = 1'b0;
    TRIG = 1'b1;
    cycle();
    chk("dis_err",         32'(FRAME_ERR),     32'd0);
    chk("dis_cnt",         32'(UNDERRUN_CNT),  32'd0);
    chk("dis_data",        data_zero(),        32'd1);
    chk("dis_tready",      32'(s_axis.tready), 32'd0);
    chk("dis_trig_out",    32'(TRIG_OUT),      32'd0);
    EN = 1'b1;
    cycle();
    chk("en_no_fire",      32'(TRIG_OUT),      32'd0);
    chk("en_tready",       32'(s_axis.tready), 32'd1);
    TRIG = 1'b0;
    cycle();

    // Backpressure while FULL
    send(0, WORDS, 32'h4000_0000, WORDS - 1);
    s_axis.tdata  = 32'hA5A5_A5A5;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b1;
    repeat (3) cycle();
    chk("bp_tready_low",   32'(s_axis.tready), 32'd0);
    chk("bp_ready",        32'(FRAME_READY),   32'd1);
    trig_hi();
    chk("bp_tready_swap",  32'(s_axis.tready), 32'd1);
    chk("bp_frame",        frame_errs(32'h4000_0000), 32'd0);
    TRIG = 1'b0;
    cycle();
    s_axis.tvalid = 1'b0;
    chk("bp_trig_out_off", 32'(TRIG_OUT),      32'd0);
    send(1, WORDS - 1, 32'h5000_0000, WORDS - 1);
    chk("bp_ready_next",   32'(FRAME_READY),   32'd1);
    trig_hi();
    chk("bp_word0",        DATA[31:0],         32'hA5A5_A5A5);
    chk("bp_word1",        DATA[63:32],        32'h5000_0001);
    chk("bp_word99",       DATA[3199:3168],    32'h5000_0063);
    trig_lo();

    // Trigger on the same edge as the last word
    send(0, WORDS - 1, 32'h6000_0000, WORDS - 1);
    s_axis.tdata  = 32'h6000_0063;
    s_axis.tlast  = 1'b1;
    s_axis.tvalid = 1'b1;
    TRIG          = 1'b1;
    cycle();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    chk("co_cnt",          32'(UNDERRUN_CNT),  32'd1);
    chk("co_data_blank",   data_zero(),        32'd1);
    chk("co_ready",        32'(FRAME_READY),   32'd1);
    chk("co_trig_out",     32'(TRIG_OUT),      32'd1);
    trig_lo();
    trig_hi();
    chk("co_frame",        frame_errs(32'h6000_0000), 32'd0);
    chk("co_cnt_hold",     32'(UNDERRUN_CNT),  32'd1);
    chk("co_ready_post",   32'(FRAME_READY),   32'd0);
    trig_lo();

    // Asynchronous reset mid-fill
    send(0, 40, 32'h7000_0000, WORDS - 1);
    #2 SYS_RESETN = 1'b0;
    #1;
    chk("ar_data",         data_zero(),        32'd1);
    chk("ar_cnt",          32'(UNDERRUN_CNT),  32'd0);
    chk("ar_tready",       32'(s_axis.tready), 32'd0);
    chk("ar_ready",        32'(FRAME_READY),   32'd0);
    @(negedge SYS_CLK);
    SYS_RESETN = 1'b1;
    cycle();
    send(0, WORDS, 32'h8000_0000, WORDS - 1);
    chk("ar_ready_full",   32'(FRAME_READY),   32'd1);
    trig_hi();
    chk("ar_frame",        frame_errs(32'h8000_0000), 32'd0);
    chk("ar_cnt_zero",     32'(UNDERRUN_CNT),  32'd0);
    trig_lo();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
